// File: rtl/posi_satd_2d_engine.sv
// rtl/posi_satd_2d_engine.sv - 2-D Hadamard SATD engine (one 8x8 or two 4x4 blocks per pass)
module posi_satd_2d_engine #(
    parameter int         DATA_WIDTH = 9,
    parameter int         COST_WIDTH = DATA_WIDTH + 12,
    parameter logic [1:0] SIZE_04    = 2'd1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [1:0]                size_i,
    input  logic                      flush_i,
    input  logic                      val_i,
    output logic                      rdy_o,
    input  logic [DATA_WIDTH*8-1:0]   dat_i,
    output logic                      val_o,
    output logic [2*COST_WIDTH-1:0]   cost_o,
    output logic [1:0]                size_o
);
    localparam int RW = DATA_WIDTH + 3;
    localparam int CW = DATA_WIDTH + 6;
    localparam int SW = CW + 3;

    typedef logic [7:0][CW-1:0] vec_t;
    typedef enum logic [1:0] {LOAD, COL, OUT} state_t;

    state_t                  state;
    logic [2:0]              cnt, col;
    logic [1:0]              blk_size, size_r;
    logic [COST_WIDTH-1:0]   acc0, acc1, nxt0, nxt1;
    logic                    rdy_r, val_r;
    logic [2*COST_WIDTH-1:0] cost_r;
    logic [RW-1:0]           rbuf [8][8];

    logic                    row_4x4, col_4x4, take, last_row, to_acc1;
    vec_t                    row_in, row_out, col_in, col_out;
    logic [CW-1:0]           mag [8];
    logic [SW-1:0]           colsum;

    // Bypassing stage 1 splits the 8-point transform into two independent 4-point halves.
    function automatic vec_t had8(input vec_t x, input logic bypass);
        vec_t a, b, c;
        for (int i = 0; i < 4; i++) begin
            a[i]   = bypass ? x[i]   : x[i] + x[i+4];
            a[i+4] = bypass ? x[i+4] : x[i] - x[i+4];
        end
        for (int h = 0; h < 8; h += 4) begin
            for (int j = 0; j < 2; j++) begin
                b[h+j]   = a[h+j] + a[h+j+2];
                b[h+j+2] = a[h+j] - a[h+j+2];
            end
        end
        for (int k = 0; k < 8; k += 2) begin
            c[k]   = b[k] + b[k+1];
            c[k+1] = b[k] - b[k+1];
        end
        return c;
    endfunction

    always_comb begin
        row_4x4  = (((cnt == 3'd0) ? size_i : blk_size) == SIZE_04);
        col_4x4  = (blk_size == SIZE_04);
        take     = val_i & rdy_r & ~flush_i;
        last_row = row_4x4 ? (cnt == 3'd3) : (cnt == 3'd7);
        row_in   = '0;
        col_in   = '0;
        for (int k = 0; k < 8; k++) begin
            row_in[k] = CW'($signed(dat_i[DATA_WIDTH*(8-k)-1 -: DATA_WIDTH]));
            if (!(col_4x4 && k >= 4))
                col_in[k] = CW'($signed(rbuf[k][col]));
        end
        row_out = had8(row_in, row_4x4);
        col_out = had8(col_in, col_4x4);
        colsum  = '0;
        for (int k = 0; k < 8; k++) begin
            mag[k] = col_out[k][CW-1] ? (~col_out[k] + CW'(1)) : col_out[k];
            if (!col_4x4 || k < 4)
                colsum = colsum + SW'(mag[k]);
        end
        to_acc1 = col_4x4 & col[2];
        nxt0    = acc0 + (to_acc1 ? '0 : COST_WIDTH'(colsum));
        nxt1    = acc1 + (to_acc1 ? COST_WIDTH'(colsum) : '0);
    end

    always_ff @(posedge clk) begin
        if (take) begin
            for (int k = 0; k < 8; k++)
                rbuf[cnt][k] <= row_out[k][RW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= LOAD;
            cnt      <= 3'd0;
            col      <= 3'd0;
            blk_size <= 2'd0;
            acc0     <= '0;
            acc1     <= '0;
            rdy_r    <= 1'b1;
            val_r    <= 1'b0;
            cost_r   <= '0;
            size_r   <= 2'd0;
        end else if (flush_i) begin
            state <= LOAD;
            cnt   <= 3'd0;
            col   <= 3'd0;
            acc0  <= '0;
            acc1  <= '0;
            rdy_r <= 1'b1;
            val_r <= 1'b0;
        end else begin
            case (state)
                LOAD, OUT: begin
                    if (state == OUT) begin
                        val_r <= 1'b0;
                        state <= LOAD;
                    end
                    if (take) begin
                        if (cnt == 3'd0)
                            blk_size <= size_i;
                        if (last_row) begin
                            cnt   <= 3'd0;
                            col   <= 3'd0;
                            rdy_r <= 1'b0;
                            state <= COL;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                COL: begin
                    col <= col + 3'd1;
                    if (col == 3'd7) begin
                        acc0   <= '0;
                        acc1   <= '0;
                        cost_r <= col_4x4 ? {(nxt0 + COST_WIDTH'(1)) >> 1, (nxt1 + COST_WIDTH'(1)) >> 1}
                                          : {(nxt0 + COST_WIDTH'(2)) >> 2, {COST_WIDTH{1'b0}}};
                        size_r <= blk_size;
                        val_r  <= 1'b1;
                        rdy_r  <= 1'b1;
                        state  <= OUT;
                    end else begin
                        acc0 <= nxt0;
                        acc1 <= nxt1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // flush_i during OUT must kill the pulse in that same cycle.
    assign val_o  = val_r & ~flush_i;
    assign rdy_o  = rdy_r;
    assign cost_o = cost_r;
    assign size_o = size_r;
endmodule

// File: tb/tb_posi_satd_2d_engine.sv
// tb/tb_posi_satd_2d_engine.sv - randomized self-checking bench for posi_satd_2d_engine
module tb_posi_satd_2d_engine;
    localparam int         DW      = 9;
    localparam int         CWD     = DW + 12;
    localparam logic [1:0] SIZE_04 = 2'd1;
    localparam logic [1:0] SIZE_08 = 2'd2;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [1:0]            size_i = 2'd0;
    logic                  flush_i = 1'b0;
    logic                  val_i = 1'b0;
    logic                  rdy_o;
    logic [DW*8-1:0]       dat_i = '0;
    logic                  val_o;
    logic [2*CWD-1:0]      cost_o;
    logic [1:0]            size_o;

    posi_satd_2d_engine #(.DATA_WIDTH(DW), .COST_WIDTH(CWD), .SIZE_04(SIZE_04)) dut (
        .clk(clk), .rstn(rstn), .size_i(size_i), .flush_i(flush_i), .val_i(val_i),
        .rdy_o(rdy_o), .dat_i(dat_i), .val_o(val_o), .cost_o(cost_o), .size_o(size_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*CWD-1:0] cost;
        logic [1:0]       size;
        int               vcyc;
    } exp_t;

    exp_t expq[$];
    exp_t me;
    int   blk[8][8];
    int   vectors = 0;
    int   errs = 0;
    int   cyc = 0;
    int   lowrun = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int hs(input int u, input int v);
        return ($countones(u & v) & 1) ? -1 : 1;
    endfunction

    // Direct 2-D Hadamard by definition: sum over all samples of the +-1 basis.
    function automatic int satd(input int n, input int c0);
        int tot, s;
        tot = 0;
        for (int u = 0; u < n; u++)
            for (int v = 0; v < n; v++) begin
                s = 0;
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < n; j++)
                        s += hs(u, i) * hs(v, j) * blk[i][c0+j];
                tot += (s < 0) ? -s : s;
            end
        return tot;
    endfunction

    function automatic logic [2*CWD-1:0] model_cost(input logic [1:0] sz);
        logic [CWD-1:0] l0, l1;
        if (sz == SIZE_04) begin
            l0 = CWD'((satd(4, 0) + 1) >> 1);
            l1 = CWD'((satd(4, 4) + 1) >> 1);
        end else begin
            l0 = CWD'((satd(8, 0) + 2) >> 2);
            l1 = '0;
        end
        return {l0, l1};
    endfunction

    task automatic drive_row(input int r);
        for (int k = 0; k < 8; k++)
            dat_i[DW*(8-k)-1 -: DW] = DW'(blk[r][k]);
    endtask

    task automatic rand_blk();
        int mode;
        mode = $urandom_range(0, 3);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (mode == 0) blk[i][j] = ($urandom_range(0, 1) != 0) ? 255 : -256;
                else           blk[i][j] = int'($urandom_range(0, 511)) - 256;
    endtask

    task automatic send_block(input logic [1:0] sz, input bit gaps, input int flush_at, input bit no_result);
        int   n, g, waitc;
        exp_t e;
        n      = (sz == SIZE_04) ? 4 : 8;
        e.cost = model_cost(sz);
        e.size = sz;
        e.vcyc = 0;
        for (int r = 0; r < n; r++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    val_i = 1'b0;
                end
            end
            @(negedge clk);
            if (r == flush_at) begin
                flush_i = 1'b1;
                val_i   = 1'b1;
                drive_row(r);
                @(negedge clk);
                flush_i = 1'b0;
                val_i   = 1'b0;
                return;
            end
            val_i  = 1'b1;
            drive_row(r);
            size_i = (r == 0) ? sz : 2'($urandom);
            waitc  = 0;
            while (!rdy_o && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            if (!rdy_o) begin
                vectors++;
                errs++;
                $display("FAIL rdy_timeout: got rdy_o=0 expected 1 within 50 cycles");
            end else if (r == n - 1 && !no_result) begin
                e.vcyc = cyc + 9;
                expq.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        while (expq.size() != 0 && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_pending", 64'(expq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            lowrun = 0;
        end else begin
            if (val_o) begin
                if (expq.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL unexpected_val_o: got cost_o=%0h expected no val_o", cost_o);
                end else begin
                    me = expq.pop_front();
                    chk("cost", 64'(cost_o), 64'(me.cost));
                    chk("size", 64'(size_o), 64'(me.size));
                    chk("latency_cycle", 64'(cyc), 64'(me.vcyc));
                end
            end
            if (!rdy_o) begin
                lowrun++;
            end else if (lowrun != 0) begin
                chk("rdy_low_run", 64'(lowrun), 64'd8);
                lowrun = 0;
            end
        end
    end

    initial begin
        logic [1:0] sz;
        repeat (2) @(negedge clk);
        chk("reset_rdy", 64'(rdy_o), 64'd1);
        chk("reset_val", 64'(val_o), 64'd0);
        chk("reset_cost", 64'(cost_o), 64'd0);
        chk("reset_size", 64'(size_o), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = 0;
        chk("model_zero", 64'(model_cost(SIZE_08)), 64'd0);
        send_block(SIZE_08, 1'b1, -1, 1'b0);

        // Directed blocks back-to-back with val_i held high.
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = 1;
        chk("model_ones", 64'(model_cost(SIZE_08)), {22'd0, 21'd16, 21'd0});
        send_block(SIZE_08, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = ((i + j) % 2 != 0) ? -1 : 1;
        chk("model_checker", 64'(model_cost(SIZE_08)), {22'd0, 21'd16, 21'd0});
        send_block(SIZE_08, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = -256;
        chk("model_min", 64'(model_cost(SIZE_08)), {22'd0, 21'd4096, 21'd0});
        send_block(SIZE_08, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = (j < 4) ? 1 : 0;
        chk("model_4x4_a", 64'(model_cost(SIZE_04)), {22'd0, 21'd8, 21'd0});
        send_block(SIZE_04, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = (j < 4) ? -3 : 2;
        chk("model_4x4_b", 64'(model_cost(SIZE_04)), {22'd0, 21'd24, 21'd16});
        send_block(SIZE_04, 1'b0, -1, 1'b0);
        @(negedge clk);
        val_i = 1'b0;
        drain();

        // Flush after three rows, then a normal block.
        rand_blk();
        send_block(SIZE_08, 1'b0, 3, 1'b0);
        rand_blk();
        send_block(SIZE_08, 1'b1, -1, 1'b0);
        @(negedge clk);
        val_i = 1'b0;
        drain();

        // Reset pulsed during COL, then a normal block.
        rand_blk();
        send_block(SIZE_08, 1'b0, -1, 1'b1);
        @(negedge clk);
        val_i = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        rand_blk();
        send_block(SIZE_04, 1'b1, -1, 1'b0);
        @(negedge clk);
        val_i = 1'b0;
        drain();

        for (int b = 0; b < 40; b++) begin
            rand_blk();
            sz = 2'($urandom_range(0, 3));
            send_block(sz, 1'($urandom_range(0, 1)), -1, 1'b0);
        end
        @(negedge clk);
        val_i = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
